// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between the ALU writeback
// stage (requester 0) and the multi-cycle CNN/MAC unit (requester 1).
// Arbitration is round-robin with a valid/ready handshake. The write port
// is driven from registers, so a request accepted at edge k is visible on
// rf_regwrite/rf_rd/rf_writedata during cycle k+1.
//
// Writes addressed to x0 are accepted but never reach the register file.
// They are counted instead in a saturating 8-bit counter.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,

    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,

    output logic              rf_regwrite,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_writedata,
    output logic [7:0]        x0_drops
);

    localparam logic [7:0] DROPS_MAX = 8'hFF;

    // Requester that won the most recent transfer. It resets to 1 so that
    // requester 0 wins the first contention.
    logic              last_grant_q, last_grant_d;

    logic              regwrite_q,   regwrite_d;
    logic [ADDR_W-1:0] rd_q,         rd_d;
    logic [DATA_W-1:0] data_q,       data_d;
    logic [7:0]        drops_q,      drops_d;

    logic              grant0, grant1;
    logic              xfer;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;
    logic              sel_is_x0;

    // Round-robin grant; nothing is granted during hold or reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the if/else leaves a value unassigned (no latch).
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && !hold) begin
            if (req0_valid && !req1_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid && !req0_valid) begin
                grant1 = 1'b1;
            end else if (req0_valid && req1_valid) begin
                // Under contention the requester that did not win last time goes.
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // The grant is one-hot, so a transfer is simply "anyone granted".
    assign xfer      = grant0 | grant1;
    assign sel_rd    = grant1 ? req1_rd   : req0_rd;
    assign sel_data  = grant1 ? req1_data : req0_data;
    assign sel_is_x0 = (sel_rd == '0);

    // Next state of the write port, the round-robin pointer and the x0 counter.
    always_comb begin
        regwrite_d   = 1'b0;
        rd_d         = rd_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        drops_d      = drops_q;

        if (xfer) begin
            last_grant_d = grant1;
            if (sel_is_x0) begin
                // x0 is hard-wired zero: accept the request, drop the write.
                if (drops_q != DROPS_MAX) begin
                    drops_d = drops_q + 8'd1;
                end
            end else begin
                regwrite_d = 1'b1;
                rd_d       = sel_rd;
                data_d     = sel_data;
            end
        end
    end

    // State registers; reset discards any pending registered write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regwrite_q   <= 1'b0;
            rd_q         <= '0;
            data_q       <= '0;
            last_grant_q <= 1'b1;
            drops_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its next value from the same pre-edge state.
            regwrite_q   <= regwrite_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
            drops_q      <= drops_d;
        end
    end

    assign rf_regwrite  = regwrite_q;
    assign rf_rd        = rd_q;
    assign rf_writedata = data_q;
    assign x0_drops     = drops_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed, table-driven bench for regfile_wb_arbiter. Each vector is applied
// just after a rising edge. The combinational readies are checked before the
// next edge, and the registered outputs are checked 1 ns after it.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              reset;
    logic              hold;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_rd,    req1_rd;
    logic [DATA_W-1:0] req0_data,  req1_data;
    logic              req0_ready, req1_ready;
    logic              rf_regwrite;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_writedata;
    logic [7:0]        x0_drops;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .hold         (hold),
        .req0_valid   (req0_valid),
        .req0_rd      (req0_rd),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_rd      (req1_rd),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .rf_regwrite  (rf_regwrite),
        .rf_rd        (rf_rd),
        .rf_writedata (rf_writedata),
        .x0_drops     (x0_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic              hold;
        logic              v0;
        logic [ADDR_W-1:0] rd0;
        logic [DATA_W-1:0] d0;
        logic              v1;
        logic [ADDR_W-1:0] rd1;
        logic [DATA_W-1:0] d1;
        logic              exp_r0;
        logic              exp_r1;
        logic              exp_we;
        logic [ADDR_W-1:0] exp_rd;
        logic [DATA_W-1:0] exp_data;
        logic [7:0]        exp_drops;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic h,
                       input logic v0, input logic [ADDR_W-1:0] rd0, input logic [DATA_W-1:0] d0,
                       input logic v1, input logic [ADDR_W-1:0] rd1, input logic [DATA_W-1:0] d1,
                       input logic r0, input logic r1, input logic we,
                       input logic [ADDR_W-1:0] erd, input logic [DATA_W-1:0] edata,
                       input logic [7:0] edrops);
        vec_t v;
        v.hold = h;  v.v0 = v0; v.rd0 = rd0; v.d0 = d0;
        v.v1 = v1;   v.rd1 = rd1; v.d1 = d1;
        v.exp_r0 = r0; v.exp_r1 = r1; v.exp_we = we;
        v.exp_rd = erd; v.exp_data = edata; v.exp_drops = edrops;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic h,
                         input logic v0, input logic [ADDR_W-1:0] rd0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [ADDR_W-1:0] rd1, input logic [DATA_W-1:0] d1);
        hold = h;
        req0_valid = v0; req0_rd = rd0; req0_data = d0;
        req1_valid = v1; req1_rd = rd1; req1_data = d1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic ready_ok;

    initial begin
        // ---- vector table (expected values computed by hand) ----
        // Idle after reset: no readies, outputs stay zero.
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 5'd0, 32'h0, 8'd0);
        // req0 alone, rd=5 data=5, then an idle cycle.
        add(0, 1, 5, 32'h5, 0, 0, 0,   1, 0, 1, 5'd5, 32'h5, 8'd0);
        add(0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 5'd5, 32'h5, 8'd0);
        // req1 alone, rd=7 data=7 -> last_grant becomes 1.
        add(0, 0, 0, 0, 1, 7, 32'h7,   0, 1, 1, 5'd7, 32'h7, 8'd0);
        // Continuous contention: grants 0,1,0,1,0,1.
        for (int i = 0; i < 3; i++) begin
            add(0, 1, 1, 32'h11, 1, 2, 32'h22,  1, 0, 1, 5'd1, 32'h11, 8'd0);
            add(0, 1, 1, 32'h11, 1, 2, 32'h22,  0, 1, 1, 5'd2, 32'h22, 8'd0);
        end
        // hold for 4 cycles with both valid: nothing granted, port holds.
        for (int i = 0; i < 4; i++)
            add(1, 1, 1, 32'h11, 1, 2, 32'h22,  0, 0, 0, 5'd2, 32'h22, 8'd0);
        // hold released: last_grant=1 so req0 wins.
        add(0, 1, 1, 32'h11, 1, 2, 32'h22,  1, 0, 1, 5'd1, 32'h11, 8'd0);
        // x0 drops from req1: accepted, no write, counter climbs.
        for (int i = 1; i <= 3; i++)
            add(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF,  0, 1, 0, 5'd1, 32'h11, 8'(i));

        // ---- reset state ----
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset_regwrite",  32'(rf_regwrite),  32'h0);
        check("reset_rd",        32'(rf_rd),        32'h0);
        check("reset_writedata", rf_writedata,      32'h0);
        check("reset_x0_drops",  32'(x0_drops),     32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // ---- table-driven vectors ----
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].hold, vecs[i].v0, vecs[i].rd0, vecs[i].d0,
                  vecs[i].v1, vecs[i].rd1, vecs[i].d1);
            #1;
            check($sformatf("v%0d_req0_ready", i), 32'(req0_ready), 32'(vecs[i].exp_r0));
            check($sformatf("v%0d_req1_ready", i), 32'(req1_ready), 32'(vecs[i].exp_r1));
            tick();
            check($sformatf("v%0d_regwrite", i),  32'(rf_regwrite), 32'(vecs[i].exp_we));
            check($sformatf("v%0d_rd", i),        32'(rf_rd),       32'(vecs[i].exp_rd));
            check($sformatf("v%0d_writedata", i), rf_writedata,     vecs[i].exp_data);
            check($sformatf("v%0d_x0_drops", i),  32'(x0_drops),    32'(vecs[i].exp_drops));
        end

        // ---- x0 counter saturation: 297 further drops (300 total) ----
        ready_ok = 1'b1;
        drive(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF);
        for (int i = 4; i <= 300; i++) begin
            #1;
            if (req1_ready !== 1'b1 || req0_ready !== 1'b0) ready_ok = 1'b0;
            tick();
            if (rf_regwrite !== 1'b0) ready_ok = 1'b0;
            if (i == 255) check("drops_at_255", 32'(x0_drops), 32'd255);
        end
        check("drops_ready_and_no_write", 32'(ready_ok), 32'h1);
        check("drops_saturated_300",      32'(x0_drops), 32'd255);
        check("drops_port_held_rd",       32'(rf_rd),    32'd1);

        // ---- reset pulsed one cycle after a req0 transfer ----
        drive(0, 1, 3, 32'h6, 0, 0, 0);
        #1;
        check("pre_reset_req0_ready", 32'(req0_ready), 32'h1);
        tick();
        check("pre_reset_regwrite",  32'(rf_regwrite), 32'h1);
        check("pre_reset_rd",        32'(rf_rd),       32'd3);
        check("pre_reset_writedata", rf_writedata,     32'h6);
        // Both requesters present while reset is applied mid-cycle.
        drive(0, 1, 1, 32'h11, 1, 2, 32'h22);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_regwrite",  32'(rf_regwrite), 32'h0);
        check("async_reset_rd",        32'(rf_rd),       32'h0);
        check("async_reset_writedata", rf_writedata,     32'h0);
        check("async_reset_drops",     32'(x0_drops),    32'h0);
        check("reset_ready0_low",      32'(req0_ready),  32'h0);
        check("reset_ready1_low",      32'(req1_ready),  32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        // last_grant is back to 1, so the first contention goes to req0.
        check("post_reset_req0_ready", 32'(req0_ready), 32'h1);
        check("post_reset_req1_ready", 32'(req1_ready), 32'h0);
        @(posedge clk);
        #1;
        check("post_reset_regwrite", 32'(rf_regwrite), 32'h1);
        check("post_reset_rd",       32'(rf_rd),       32'd1);
        check("post_reset_data",     rf_writedata,     32'h11);
        #1;
        check("post_reset_second_req1", 32'(req1_ready), 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
